// File: rtl/comparer1_driver.sv
// comparer1_driver: one-button self-test for a 1-bit comparator.
// A start request sweeps {a,b} through 00,01,10,11. Each vector is held for
// DWELL cycles, and the lt/eq/gt LEDs are sampled SETTLE cycles after the
// vector is applied. The block records a per-vector fail mask, a pass flag
// for the last sweep and a saturating count of mismatching vectors.
module comparer1_driver #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       led_lt,
  input  logic       led_eq,
  input  logic       led_gt,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] err_cnt
);

  // Hold counter is just wide enough to reach DWELL-1.
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] LAST_C   = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_q, a_d;
  logic            b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [3:0]      fail_mask_q, fail_mask_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  // Error count stops at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A vector passes only if all three LEDs match the expected one-hot code.
  function automatic logic vec_mismatch(input logic va, input logic vb,
                                        input logic lt, input logic eq,
                                        input logic gt);
    logic [2:0] expected;
    expected = {~va & vb, ~(va ^ vb), va & ~vb};
    return {lt, eq, gt} != expected;
  endfunction

  // Next-state and output logic for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = HOLD;
          vec_d       = 2'd0;
          cnt_d       = '0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          fail_mask_d = 4'd0;
          pass_d      = 1'b0;
        end
      end

      HOLD: begin
        a_d = vec_q[1];
        b_d = vec_q[0];
        if (cnt_q == SETTLE_C) begin
          if (vec_mismatch(vec_q[1], vec_q[0], led_lt, led_eq, led_gt)) begin
            fail_mask_d[vec_q] = 1'b1;
            err_cnt_d          = sat_inc(err_cnt_q);
          end
        end
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (vec_q != 2'd3) begin
            vec_d = vec_q + 2'd1;
            a_d   = vec_d[1];
            b_d   = vec_d[0];
          end else begin
            // fail_mask_d already includes a comparison made on this same
            // edge, which happens when SETTLE == DWELL-1.
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_mask_d == 4'd0);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FINISH: begin
        // A start still held here chains straight into the next sweep.
        if (start) begin
          state_d     = HOLD;
          vec_d       = 2'd0;
          cnt_d       = '0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b1;
          fail_mask_d = 4'd0;
          pass_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      cnt_q       <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign err_cnt   = err_cnt_q;

endmodule
